// File: rtl/matmul_tile_scheduler_if.sv
// ============================================================================
// Module      : matmul_tile_scheduler_if
// Description : Job configuration and AGU handshake bundle for the tile
//               scheduler. Adds perf_wait_cycles when TILE_SCHED_PERF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_tile_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
);
    logic                  start;
    logic [IDX_WIDTH-1:0]  M, N, K;
    logic [IDX_WIDTH-1:0]  TM, TN, TK;
    logic [ADDR_WIDTH-1:0] baseA, baseB, baseC;
    logic                  tile_ready;
    logic                  tile_done;

    logic                  start_tile;
    logic [ADDR_WIDTH-1:0] baseA_tile, baseB_tile, baseC_tile;
    logic [IDX_WIDTH-1:0]  eTM, eTN, eTK;
    logic [IDX_WIDTH-1:0]  TM_cfg, TN_cfg, TK_cfg, FULL_K, FULL_N;
    logic                  acc_first, acc_last;
    logic                  busy;
    logic                  job_done;
    logic                  cfg_err;
    logic [15:0]           tile_cnt;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0]           perf_wait_cycles;

    modport master (
        input  start, M, N, K, TM, TN, TK, baseA, baseB, baseC, tile_ready, tile_done,
        output start_tile, baseA_tile, baseB_tile, baseC_tile, eTM, eTN, eTK,
               TM_cfg, TN_cfg, TK_cfg, FULL_K, FULL_N, acc_first, acc_last,
               busy, job_done, cfg_err, tile_cnt, perf_wait_cycles
    );

    modport slave (
        output start, M, N, K, TM, TN, TK, baseA, baseB, baseC, tile_ready, tile_done,
        input  start_tile, baseA_tile, baseB_tile, baseC_tile, eTM, eTN, eTK,
               TM_cfg, TN_cfg, TK_cfg, FULL_K, FULL_N, acc_first, acc_last,
               busy, job_done, cfg_err, tile_cnt, perf_wait_cycles
    );
`else
    modport master (
        input  start, M, N, K, TM, TN, TK, baseA, baseB, baseC, tile_ready, tile_done,
        output start_tile, baseA_tile, baseB_tile, baseC_tile, eTM, eTN, eTK,
               TM_cfg, TN_cfg, TK_cfg, FULL_K, FULL_N, acc_first, acc_last,
               busy, job_done, cfg_err, tile_cnt
    );

    modport slave (
        output start, M, N, K, TM, TN, TK, baseA, baseB, baseC, tile_ready, tile_done,
        input  start_tile, baseA_tile, baseB_tile, baseC_tile, eTM, eTN, eTK,
               TM_cfg, TN_cfg, TK_cfg, FULL_K, FULL_N, acc_first, acc_last,
               busy, job_done, cfg_err, tile_cnt
    );
`endif

endinterface

`default_nettype wire

// File: rtl/matmul_tile_scheduler.sv
// ============================================================================
// Module      : matmul_tile_scheduler
// Description : Walks a C = A*B job tile by tile (m, k, n order) and drives the
//               per-tile AGU. Optional TILE_SCHED_PERF_EN adds a wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_tile_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matmul_tile_scheduler_if.master sch_io
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_ISSUE  = 3'd1;
    localparam logic [2:0]  S_WAIT   = 3'd2;
    localparam logic [2:0]  S_NEXT   = 3'd3;
    localparam logic [2:0]  S_FINISH = 3'd4;
    localparam logic [15:0] C_TILE_CNT_MAX = 16'hFFFF;

    logic [2:0]            state_q, state_d;
    logic [IDX_WIDTH-1:0]  m_q, n_q, k_q, tm_q, tn_q, tk_q;
    logic [ADDR_WIDTH-1:0] base_a_q, base_b_q, base_c_q;
    logic [IDX_WIDTH-1:0]  m0_q, k0_q, n0_q, m0_d, k0_d, n0_d;
    logic [ADDR_WIDTH-1:0] tile_a_q, tile_b_q, tile_c_q, tile_a_d, tile_b_d, tile_c_d;
    logic [IDX_WIDTH-1:0]  etm_q, etn_q, etk_q, etm_d, etn_d, etk_d;
    logic                  acc_first_q, acc_last_q, acc_first_d, acc_last_d;
    logic [15:0]           tile_cnt_q, tile_cnt_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  load_cfg, load_tile, last_tile;

    logic                  w_idle, w_cfg_valid;
    logic [IDX_WIDTH-1:0]  w_m, w_n, w_k, w_tm, w_tn, w_tk;
    logic [ADDR_WIDTH-1:0] w_base_a, w_base_b, w_base_c;
    logic [IDX_WIDTH:0]    w_n_sum, w_k_sum, w_m_sum;
    logic [IDX_WIDTH-1:0]  w_rem_m, w_rem_n, w_rem_k;

    assign w_idle      = (state_q == S_IDLE);
    assign w_cfg_valid = (|sch_io.M) && (|sch_io.N) && (|sch_io.K) &&
                         (|sch_io.TM) && (|sch_io.TN) && (|sch_io.TK);

    // The first tile is computed straight from the ports while leaving IDLE.
    assign w_m      = w_idle ? sch_io.M     : m_q;
    assign w_n      = w_idle ? sch_io.N     : n_q;
    assign w_k      = w_idle ? sch_io.K     : k_q;
    assign w_tm     = w_idle ? sch_io.TM    : tm_q;
    assign w_tn     = w_idle ? sch_io.TN    : tn_q;
    assign w_tk     = w_idle ? sch_io.TK    : tk_q;
    assign w_base_a = w_idle ? sch_io.baseA : base_a_q;
    assign w_base_b = w_idle ? sch_io.baseB : base_b_q;
    assign w_base_c = w_idle ? sch_io.baseC : base_c_q;

    assign w_n_sum = {1'b0, n0_q} + {1'b0, tn_q};
    assign w_k_sum = {1'b0, k0_q} + {1'b0, tk_q};
    assign w_m_sum = {1'b0, m0_q} + {1'b0, tm_q};

    always_comb begin
        m0_d      = m0_q;
        k0_d      = k0_q;
        n0_d      = n0_q;
        last_tile = 1'b0;
        if (w_idle) begin
            m0_d = '0;
            k0_d = '0;
            n0_d = '0;
        end else if (state_q == S_NEXT) begin
            if (w_n_sum >= {1'b0, n_q}) begin
                n0_d = '0;
                if (w_k_sum >= {1'b0, k_q}) begin
                    k0_d = '0;
                    if (w_m_sum >= {1'b0, m_q}) begin
                        last_tile = 1'b1;
                    end else begin
                        m0_d = w_m_sum[IDX_WIDTH-1:0];
                    end
                end else begin
                    k0_d = w_k_sum[IDX_WIDTH-1:0];
                end
            end else begin
                n0_d = w_n_sum[IDX_WIDTH-1:0];
            end
        end
    end

    // Tile geometry for the indices about to be issued; indices are always < dims.
    assign w_rem_m = w_m - m0_d;
    assign w_rem_n = w_n - n0_d;
    assign w_rem_k = w_k - k0_d;

    always_comb begin
        tile_a_d    = w_base_a + ADDR_WIDTH'(m0_d) * ADDR_WIDTH'(w_k) + ADDR_WIDTH'(k0_d);
        tile_b_d    = w_base_b + ADDR_WIDTH'(k0_d) * ADDR_WIDTH'(w_n) + ADDR_WIDTH'(n0_d);
        tile_c_d    = w_base_c + ADDR_WIDTH'(m0_d) * ADDR_WIDTH'(w_n) + ADDR_WIDTH'(n0_d);
        etm_d       = (w_tm < w_rem_m) ? w_tm : w_rem_m;
        etn_d       = (w_tn < w_rem_n) ? w_tn : w_rem_n;
        etk_d       = (w_tk < w_rem_k) ? w_tk : w_rem_k;
        acc_first_d = (k0_d == '0);
        acc_last_d  = (({1'b0, k0_d} + {1'b0, w_tk}) >= {1'b0, w_k});
    end

    always_comb begin
        state_d    = state_q;
        load_cfg   = 1'b0;
        load_tile  = 1'b0;
        cfg_err_d  = 1'b0;
        tile_cnt_d = tile_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sch_io.start) begin
                    if (w_cfg_valid) begin
                        state_d    = S_ISSUE;
                        load_cfg   = 1'b1;
                        load_tile  = 1'b1;
                        tile_cnt_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (sch_io.tile_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sch_io.tile_done) begin
                    state_d = S_NEXT;
                    if (tile_cnt_q != C_TILE_CNT_MAX) begin
                        tile_cnt_d = tile_cnt_q + 16'd1;
                    end
                end
            end
            S_NEXT: begin
                if (last_tile) begin
                    state_d = S_FINISH;
                end else begin
                    state_d   = S_ISSUE;
                    load_tile = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            tm_q        <= '0;
            tn_q        <= '0;
            tk_q        <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            m0_q        <= '0;
            k0_q        <= '0;
            n0_q        <= '0;
            tile_a_q    <= '0;
            tile_b_q    <= '0;
            tile_c_q    <= '0;
            etm_q       <= '0;
            etn_q       <= '0;
            etk_q       <= '0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            tile_cnt_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            m0_q       <= m0_d;
            k0_q       <= k0_d;
            n0_q       <= n0_d;
            tile_cnt_q <= tile_cnt_d;
            cfg_err_q  <= cfg_err_d;
            if (load_cfg) begin
                m_q      <= sch_io.M;
                n_q      <= sch_io.N;
                k_q      <= sch_io.K;
                tm_q     <= sch_io.TM;
                tn_q     <= sch_io.TN;
                tk_q     <= sch_io.TK;
                base_a_q <= sch_io.baseA;
                base_b_q <= sch_io.baseB;
                base_c_q <= sch_io.baseC;
            end
            if (load_tile) begin
                tile_a_q    <= tile_a_d;
                tile_b_q    <= tile_b_d;
                tile_c_q    <= tile_c_d;
                etm_q       <= etm_d;
                etn_q       <= etn_d;
                etk_q       <= etk_d;
                acc_first_q <= acc_first_d;
                acc_last_q  <= acc_last_d;
            end
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (load_cfg) begin
            perf_q <= '0;
        end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign sch_io.perf_wait_cycles = perf_q;
`endif

    assign sch_io.start_tile = (state_q == S_ISSUE) && sch_io.tile_ready;
    assign sch_io.busy       = !w_idle;
    assign sch_io.job_done   = (state_q == S_FINISH);
    assign sch_io.cfg_err    = cfg_err_q;
    assign sch_io.tile_cnt   = tile_cnt_q;
    assign sch_io.baseA_tile = tile_a_q;
    assign sch_io.baseB_tile = tile_b_q;
    assign sch_io.baseC_tile = tile_c_q;
    assign sch_io.eTM        = etm_q;
    assign sch_io.eTN        = etn_q;
    assign sch_io.eTK        = etk_q;
    assign sch_io.acc_first  = acc_first_q;
    assign sch_io.acc_last   = acc_last_q;
    assign sch_io.TM_cfg     = tm_q;
    assign sch_io.TN_cfg     = tn_q;
    assign sch_io.TK_cfg     = tk_q;
    assign sch_io.FULL_K     = k_q;
    assign sch_io.FULL_N     = n_q;

endmodule

`default_nettype wire
